axis_frame_arbiter: RTL

- Shares one downstream AXI-Stream video slave port between NUM_SRC upstream video sources.
- Arbitration is frame-granular round-robin. A grant is taken only on a start-of-frame beat (tuser=1) and is held until the last tlast beat of the frame (LINES_PER_FRAME lines).
- Datapath is a zero-latency combinational mux; only control (grant, counters, FSM) is registered.
- Sits between the video sources and the stream slave/receive block.

---
 rtl/axis_frame_arbiter_if.sv | 31 +++
 rtl/axis_frame_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter_if.sv
// axis_frame_arbiter_if: AXI-Stream video bundle between NUM_SRC sources and one downstream slave.
// master is the arbiter's view of the bundle, slave is the surrounding sources/sink view.
interface axis_frame_arbiter_if #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]            s_axis_tvalid;
    logic [NUM_SRC-1:0]            s_axis_tready;
    logic [NUM_SRC-1:0]            s_axis_tlast;
    logic [NUM_SRC-1:0]            s_axis_tuser;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic                          m_axis_tuser;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-granular round-robin share of one AXI-Stream video sink among NUM_SRC sources.
// Define AXIS_FRAME_ARB_TIMEOUT_EN to add the stall watchdog and the timeout_err output.
module axis_frame_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int LINES_PER_FRAME = 480,
    parameter int LINE_CNT_W      = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_frame_arbiter_if.master       bus,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       sof_error
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);
    localparam int GW = $clog2(NUM_SRC);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]            r_state;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_rr_ptr;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic                  r_mid;
    logic                  r_frame_done;
    logic                  r_sof_error;

    logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_SRC-1:0]    w_elig;
    logic [NUM_SRC-1:0]    w_ready;
    logic [GW-1:0]         w_pick;
    logic [GW-1:0]         w_cand;
    logic [GW-1:0]         w_next_ptr;
    logic [LINE_CNT_W-1:0] w_line_base;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_user;
    logic                  w_stream;
    logic                  w_any;
    logic                  w_hs;
    logic                  w_restart;
    logic                  w_done;
    logic                  w_timeout;

    assign w_elig   = bus.s_axis_tvalid & bus.s_axis_tuser;
    assign w_any    = |w_elig;
    assign w_stream = (r_state == S_STREAM);

    // Descending scan so the smallest offset from r_rr_ptr is written last and wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_cand = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_cand = GW'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (w_elig[w_cand]) w_pick = w_cand;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) w_src_data[i] = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_data  = w_src_data[r_grant];
    assign w_valid = bus.s_axis_tvalid[r_grant];
    assign w_last  = bus.s_axis_tlast[r_grant];
    assign w_user  = bus.s_axis_tuser[r_grant];

    assign bus.m_axis_tdata  = w_data;
    assign bus.m_axis_tvalid = w_stream & w_valid;
    assign bus.m_axis_tlast  = w_last;
    assign bus.m_axis_tuser  = w_user;

    always_comb begin
        w_ready          = '0;
        w_ready[r_grant] = w_stream & bus.m_axis_tready;
    end
    assign bus.s_axis_tready = w_ready;

    assign w_hs        = bus.m_axis_tvalid & bus.m_axis_tready;
    // A tuser beat after any accepted beat of this grant restarts the frame count from that beat.
    assign w_restart   = w_hs & w_user & ((r_line_cnt != '0) | r_mid);
    assign w_line_base = w_restart ? '0 : r_line_cnt;
    assign w_done      = w_hs & w_last & (w_line_base == LINE_CNT_W'(LINES_PER_FRAME - 1));
    assign w_next_ptr  = (r_grant == GW'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;

`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    assign w_timeout = w_stream & ~w_valid & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt      <= (w_stream & ~w_valid & ~w_timeout) ? r_to_cnt + 1'b1 : '0;
            r_timeout_err <= w_timeout;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_line_cnt   <= '0;
            r_mid        <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_error  <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_sof_error  <= w_restart;
            if (r_state == S_IDLE) begin
                r_line_cnt <= '0;
                r_mid      <= 1'b0;
                if (w_any) begin
                    r_grant <= w_pick;
                    r_state <= S_STREAM;
                end
            end else if (w_done || w_timeout) begin
                r_state    <= S_IDLE;
                r_line_cnt <= '0;
                r_mid      <= 1'b0;
                r_rr_ptr   <= w_next_ptr;
            end else if (w_hs) begin
                r_mid      <= 1'b1;
                r_line_cnt <= w_last ? w_line_base + 1'b1 : w_line_base;
            end
        end
    end

    assign grant_id   = r_grant;
    assign busy       = w_stream;
    assign frame_done = r_frame_done;
    assign sof_error  = r_sof_error;
endmodule
